// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-wide transmit buffer feeding the UART transmitter.
// CPU pushes bytes without polling. A three-state drain FSM hands them one
// at a time to the UART, and the block also builds the MMIO TX status word.
//
// UART handshake:
//   - In IDLE, the FSM pops a byte only when the FIFO is non-empty and
//     tx_busy_flag is low.
//   - The pop presents the byte on tx_data and raises tx_begin_flag for one
//     cycle.
//   - The FSM then waits for tx_busy_flag to rise and fall again. If busy
//     never rises within BUSY_TIMEOUT cycles, the byte is treated as sent.
module uart_tx_fifo #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              clear_overflow,
    input  logic              tx_busy_flag,
    output logic [7:0]        tx_data,
    output logic              tx_begin_flag,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic [31:0]       status
);

    localparam int                TMR_W    = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(BUSY_TIMEOUT);
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    state_e              state_q;
    logic [7:0]          mem_q [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                empty_q, full_q;
    logic                overflow_q, overflow_d;
    logic [TMR_W-1:0]    timer_q;
    logic [7:0]          tx_data_q;
    logic                tx_begin_q;

    logic                push_ok;
    logic                pop;

    // A push is taken only when the FIFO is not full. A pop in the same
    // cycle never makes room for it.
    assign push_ok = wr_en & ~full_q;
    assign pop     = (state_q == IDLE) & ~empty_q & ~tx_busy_flag;

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // An overflow in the same cycle as a clear leaves the flag set.
        if (wr_en && full_q) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // FIFO bookkeeping registers. empty/full are decoded from the next count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= (count_d == '0);
            full_q     <= (count_d == DEPTH_C);
            overflow_q <= overflow_d;
        end
    end

    // Storage array. Its contents are don't-care after reset because the
    // pointers and count are cleared.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Drain FSM with registered start pulse, output byte and busy timer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            tx_data_q  <= 8'h00;
            tx_begin_q <= 1'b0;
        end else begin
            tx_begin_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        tx_data_q  <= mem_q[rd_ptr_q];
                        tx_begin_q <= 1'b1;
                        timer_q    <= TMR_LOAD;
                        state_q    <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (tx_busy_flag) begin
                        state_q <= WAIT_DONE;
                    end else if (timer_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy_flag) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // MMIO status word. Only bit 3 sees the raw busy input combinationally.
    always_comb begin
        status                 = '0;
        status[0]              = empty_q;
        status[1]              = full_q;
        status[2]              = overflow_q;
        status[3]              = (state_q != IDLE) | tx_busy_flag;
        status[8 +: ADDR_W+1]  = count_q;
    end

    assign tx_data       = tx_data_q;
    assign tx_begin_flag = tx_begin_q;
    assign empty         = empty_q;
    assign full          = full_q;
    assign count         = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed stimulus, expected bytes queued at push
// time and compared by an independent monitor on every start pulse.
module tb_uart_tx_fifo;

    logic        clock;
    logic        reset_n;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        clear_overflow;
    logic        tx_busy_flag;
    logic [7:0]  tx_data;
    logic        tx_begin_flag;
    logic        empty;
    logic        full;
    logic [4:0]  count;
    logic [31:0] status;

    // tx_busy_flag comes from a forced value or from the model UART.
    logic        use_model;
    logic        forced_busy;
    logic        model_busy;
    assign tx_busy_flag = use_model ? model_busy : forced_busy;

    logic [7:0]  exp_q[$];
    int          start_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    uart_tx_fifo #(
        .DEPTH(16),
        .ADDR_W(4),
        .BUSY_TIMEOUT(15)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .clear_overflow (clear_overflow),
        .tx_busy_flag   (tx_busy_flag),
        .tx_data        (tx_data),
        .tx_begin_flag  (tx_begin_flag),
        .empty          (empty),
        .full           (full),
        .count          (count),
        .status         (status)
    );

    // Clock and cycle counter.
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp_v);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s wait bound expired", name);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Drives one push cycle; wr_en is left high so pushes can run back to back.
    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        exp_q.push_back(b);
        tick(1);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && empty && !status[3]) && n < budget) begin
            tick(1);
            n++;
        end
        if (n >= budget) bound_fail(name);
    endtask

    // Model UART: busy rises 2 cycles after a start and stays high 10 cycles.
    initial begin
        model_busy = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (use_model && tx_begin_flag) begin
                tick(2);
                model_busy = 1'b1;
                tick(10);
                model_busy = 1'b0;
            end
        end
    end

    // Monitor: every start pulse pops the scoreboard and checks the byte.
    initial begin
        logic       prev_begin;
        logic [7:0] e;
        prev_begin = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                prev_begin = 1'b0;
            end else begin
                if (tx_begin_flag) begin
                    start_q.push_back(cyc);
                    chk("begin_while_busy", {31'b0, tx_busy_flag}, 32'd0);
                    chk("begin_back_to_back", {31'b0, prev_begin}, 32'd0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_start actual=0x%02h required=none", tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_data_order", {24'b0, tx_data}, {24'b0, e});
                    end
                end
                prev_begin = tx_begin_flag;
            end
        end
    end

    initial begin
        reset_n        = 1'b0;
        wr_en          = 1'b0;
        wr_data        = 8'h00;
        clear_overflow = 1'b0;
        use_model      = 1'b0;
        forced_busy    = 1'b0;

        // Reset values.
        tick(3);
        chk("rst_status", status, 32'h0000_0001);
        chk("rst_count", {27'b0, count}, 32'd0);
        chk("rst_begin", {31'b0, tx_begin_flag}, 32'd0);
        chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
        reset_n = 1'b1;
        tick(2);

        // Single byte with the model UART.
        use_model = 1'b1;
        push(8'h41);
        wr_en = 1'b0;
        chk("push_count", {27'b0, count}, 32'd1);
        chk("push_empty", {31'b0, empty}, 32'd0);
        tick(1);
        chk("first_begin", {31'b0, tx_begin_flag}, 32'd1);
        chk("first_data", {24'b0, tx_data}, 32'h41);
        tick(1);
        chk("begin_one_cycle", {31'b0, tx_begin_flag}, 32'd0);
        tick(20);
        chk("single_done_status", status, 32'h0000_0001);

        // Fill while busy, overflow handling.
        use_model   = 1'b0;
        forced_busy = 1'b1;
        for (int i = 1; i <= 16; i++) push(8'(i));
        wr_en = 1'b0;
        chk("fill_count", {27'b0, count}, 32'd16);
        chk("fill_full", {31'b0, full}, 32'd1);
        chk("fill_status", status, 32'h0000_100A);
        wr_en   = 1'b1;
        wr_data = 8'h99;
        tick(1);
        wr_en = 1'b0;
        chk("ovf_status", status, 32'h0000_100E);
        chk("ovf_count", {27'b0, count}, 32'd16);
        clear_overflow = 1'b1;
        tick(1);
        clear_overflow = 1'b0;
        chk("ovf_clear", status, 32'h0000_100A);
        wr_en          = 1'b1;
        clear_overflow = 1'b1;
        tick(1);
        wr_en          = 1'b0;
        clear_overflow = 1'b0;
        chk("ovf_set_wins", status, 32'h0000_100E);
        clear_overflow = 1'b1;
        tick(1);
        clear_overflow = 1'b0;
        chk("ovf_clear2", status, 32'h0000_100A);

        // Drain through the model UART.
        use_model = 1'b1;
        wait_drain("drain16", 500);
        chk("drain_empty", {31'b0, empty}, 32'd1);
        chk("drain_status", status, 32'h0000_0001);

        // Simultaneous push and pop at count 3, wrapping the pointers.
        use_model   = 1'b0;
        forced_busy = 1'b1;
        push(8'hA0);
        push(8'hA1);
        push(8'hA2);
        wr_en = 1'b0;
        chk("pp_pre_count", {27'b0, count}, 32'd3);
        for (int i = 0; i < 20; i++) begin
            forced_busy = 1'b0;
            push(8'hB0 + 8'(i));
            wr_en = 1'b0;
            tick(1);
            forced_busy = 1'b1;
            tick(1);
            forced_busy = 1'b0;
            tick(1);
            chk("pp_count", {27'b0, count}, 32'd3);
        end
        use_model = 1'b1;
        wait_drain("drain_pp", 200);

        // Timeout path: busy stuck low, starts every BUSY_TIMEOUT+2 cycles.
        use_model   = 1'b0;
        forced_busy = 1'b0;
        start_q.delete();
        push(8'hC1);
        push(8'hC2);
        push(8'hC3);
        wr_en = 1'b0;
        tick(90);
        chk("to_starts", start_q.size(), 32'd3);
        if (start_q.size() >= 3) begin
            chk("to_gap1", start_q[1] - start_q[0], 32'd17);
            chk("to_gap2", start_q[2] - start_q[1], 32'd17);
        end
        chk("to_status", status, 32'h0000_0001);

        // Reset in WAIT_DONE with five bytes still queued.
        for (int i = 0; i < 6; i++) push(8'h61 + 8'(i));
        wr_en       = 1'b0;
        forced_busy = 1'b1;
        tick(2);
        chk("wd_count", {27'b0, count}, 32'd5);
        chk("wd_active", {31'b0, status[3]}, 32'd1);
        #2;
        forced_busy = 1'b0;
        reset_n     = 1'b0;
        #1;
        chk("mid_rst_status", status, 32'h0000_0001);
        chk("mid_rst_begin", {31'b0, tx_begin_flag}, 32'd0);
        chk("mid_rst_data", {24'b0, tx_data}, 32'd0);
        exp_q.delete();
        tick(2);
        reset_n = 1'b1;
        start_q.delete();
        tick(30);
        chk("post_rst_no_start", start_q.size(), 32'd0);
        chk("post_rst_status", status, 32'h0000_0001);
        push(8'h5A);
        wr_en = 1'b0;
        tick(25);
        chk("post_rst_one_start", start_q.size(), 32'd1);
        chk("post_rst_sb_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
